// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared defaults, count-width helper and select type for the PC unit
package pc_pkg;

  localparam int ADDR_W_DEF    = 10;
  localparam int STEP_DEF      = 1;
  localparam int RESET_VEC_DEF = 0;
  localparam int RAS_DEPTH_DEF = 4;

  // Bits needed to hold an entry count from 0 up to and including depth
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int RAS_CNT_W_DEF = cnt_width(RAS_DEPTH_DEF);

  // Source of the next instruction address
  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_TGT,
    SEL_RAS
  } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with overflow/underflow pulses
module ras_stack #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic              unf
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wp_q, wp_d, top_ptr;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, empty;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  // The newest entry sits just below the write pointer, wrapping at the bottom
  assign top_ptr = (wp_q == '0) ? PTR_W'(DEPTH - 1) : wp_q - PTR_W'(1);
  assign top     = mem_q[top_ptr];
  assign count   = count_q;
  assign ovf     = push && full;
  assign unf     = pop && empty;

  // Pointer and count update; a push when full overwrites the oldest slot
  always_comb begin
    wp_d    = wp_q;
    count_d = count_q;
    if (push) begin
      wp_d = (wp_q == PTR_W'(DEPTH - 1)) ? '0 : wp_q + PTR_W'(1);
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      wp_d    = top_ptr;
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer/count registers; reset empties the stack
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never reset; entries are unreachable while count is zero
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wp_q] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with redirect, call/return stack and sticky flags
module pc_unit
  import pc_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int STEP      = STEP_DEF,
  parameter int RESET_VEC = RESET_VEC_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           redirect_valid,
  input  logic                           call_valid,
  input  logic                           ret_valid,
  input  logic [ADDR_W-1:0]              redirect_addr,
  output logic [ADDR_W-1:0]              iaddr,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_ovf,
  output logic                           ras_unf
);

  localparam int CNT_W = cnt_width(RAS_DEPTH);

  logic [ADDR_W-1:0] iaddr_q, iaddr_d, seq_addr, ras_top;
  logic [CNT_W-1:0]  count;
  logic              push, pop, ovf_pulse, unf_pulse;
  logic              ras_ovf_q, ras_unf_q;
  pc_sel_e           sel;

  assign seq_addr = iaddr_q + ADDR_W'(STEP);

  // Priority: redirect beats stall, stall masks ret, ret beats call
  always_comb begin
    sel  = SEL_SEQ;
    push = 1'b0;
    pop  = 1'b0;
    if (redirect_valid) begin
      sel = SEL_TGT;
    end else if (stall) begin
      sel = SEL_HOLD;
    end else if (ret_valid) begin
      pop = 1'b1;
      if (count != '0) sel = SEL_RAS;
    end else if (call_valid) begin
      push = 1'b1;
      sel  = SEL_TGT;
    end
  end

  // Next-address mux driven by the selected source
  always_comb begin
    case (sel)
      SEL_HOLD: iaddr_d = iaddr_q;
      SEL_TGT:  iaddr_d = redirect_addr;
      SEL_RAS:  iaddr_d = ras_top;
      default:  iaddr_d = seq_addr;
    endcase
  end

  ras_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH),
    .CNT_W  (CNT_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (seq_addr),
    .top       (ras_top),
    .count     (count),
    .ovf       (ovf_pulse),
    .unf       (unf_pulse)
  );

  // PC register and sticky flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      iaddr_q   <= ADDR_W'(RESET_VEC);
      ras_ovf_q <= 1'b0;
      ras_unf_q <= 1'b0;
    end else begin
      iaddr_q   <= iaddr_d;
      ras_ovf_q <= ras_ovf_q | ovf_pulse;
      ras_unf_q <= ras_unf_q | unf_pulse;
    end
  end

  assign iaddr     = iaddr_q;
  assign ras_count = count;
  assign ras_ovf   = ras_ovf_q;
  assign ras_unf   = ras_unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed scoreboard bench for pc_unit at default parameters
module tb_pc_unit;

  typedef struct {
    logic [9:0] iaddr;
    logic [2:0] cnt;
    logic       ovf;
    logic       unf;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, stall, redirect_valid, call_valid, ret_valid;
  logic [9:0] redirect_addr;
  logic [9:0] iaddr;
  logic [2:0] ras_count;
  logic       ras_ovf, ras_unf;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .call_valid     (call_valid),
    .ret_valid      (ret_valid),
    .redirect_addr  (redirect_addr),
    .iaddr          (iaddr),
    .ras_count      (ras_count),
    .ras_ovf        (ras_ovf),
    .ras_unf        (ras_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic compare_out();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: got 0 entries expected 1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (iaddr === e.iaddr) else begin
        errors++;
        $error("FAIL %s iaddr: got %0h expected %0h", e.tag, iaddr, e.iaddr);
      end
      checks++;
      assert (ras_count === e.cnt) else begin
        errors++;
        $error("FAIL %s ras_count: got %0d expected %0d", e.tag, ras_count, e.cnt);
      end
      checks++;
      assert (ras_ovf === e.ovf) else begin
        errors++;
        $error("FAIL %s ras_ovf: got %0b expected %0b", e.tag, ras_ovf, e.ovf);
      end
      checks++;
      assert (ras_unf === e.unf) else begin
        errors++;
        $error("FAIL %s ras_unf: got %0b expected %0b", e.tag, ras_unf, e.unf);
      end
    end
  endtask

  // Drive one cycle of controls, queue the expected post-edge state, then check it
  task automatic cyc(input logic r, input logic st, input logic rv, input logic cv,
                     input logic rt, input logic [9:0] a,
                     input logic [9:0] ei, input logic [2:0] ec,
                     input logic eo, input logic eu, input string tag);
    exp_t e;
    rst            = r;
    stall          = st;
    redirect_valid = rv;
    call_valid     = cv;
    ret_valid      = rt;
    redirect_addr  = a;
    e.iaddr = ei;
    e.cnt   = ec;
    e.ovf   = eo;
    e.unf   = eu;
    e.tag   = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    call_valid = 1'b0; ret_valid = 1'b0; redirect_addr = '0;

    // reset, then free-running count
    cyc(1,0,0,0,0,10'h000, 10'h000, 3'd0, 0, 0, "reset");
    for (int i = 1; i <= 5; i++)
      cyc(0,0,0,0,0,10'h000, 10'(i), 3'd0, 0, 0, "seq");

    // wrap at the top of the address space
    cyc(0,0,1,0,0,10'h3FF, 10'h3FF, 3'd0, 0, 0, "jump_3ff");
    cyc(0,0,0,0,0,10'h000, 10'h000, 3'd0, 0, 0, "wrap");

    // call / sequential / return
    cyc(0,0,1,0,0,10'h010, 10'h010, 3'd0, 0, 0, "jump_010");
    cyc(0,0,0,1,0,10'h100, 10'h100, 3'd1, 0, 0, "call_100");
    cyc(0,0,0,0,0,10'h000, 10'h101, 3'd1, 0, 0, "seq_101");
    cyc(0,0,0,0,0,10'h000, 10'h102, 3'd1, 0, 0, "seq_102");
    cyc(0,0,0,0,1,10'h000, 10'h011, 3'd0, 0, 0, "ret_011");

    // five nested calls into a four-deep stack, then four returns
    cyc(0,0,1,0,0,10'h020, 10'h020, 3'd0, 0, 0, "jump_020");
    cyc(0,0,0,1,0,10'h030, 10'h030, 3'd1, 0, 0, "call1");
    cyc(0,0,0,1,0,10'h040, 10'h040, 3'd2, 0, 0, "call2");
    cyc(0,0,0,1,0,10'h050, 10'h050, 3'd3, 0, 0, "call3");
    cyc(0,0,0,1,0,10'h060, 10'h060, 3'd4, 0, 0, "call4");
    cyc(0,0,0,1,0,10'h070, 10'h070, 3'd4, 1, 0, "call5_ovf");
    cyc(0,0,0,0,1,10'h000, 10'h061, 3'd3, 1, 0, "ret1");
    cyc(0,0,0,0,1,10'h000, 10'h051, 3'd2, 1, 0, "ret2");
    cyc(0,0,0,0,1,10'h000, 10'h041, 3'd1, 1, 0, "ret3");
    cyc(0,0,0,0,1,10'h000, 10'h031, 3'd0, 1, 0, "ret4");

    // reset in the middle of a call sequence discards the stack and flags
    cyc(0,0,0,1,0,10'h100, 10'h100, 3'd1, 1, 0, "call_pre_rst");
    cyc(1,1,1,1,1,10'h155, 10'h000, 3'd0, 0, 0, "rst_mid_call");
    cyc(0,0,0,0,1,10'h000, 10'h001, 3'd0, 0, 1, "ret_after_rst");
    cyc(1,0,0,0,0,10'h000, 10'h000, 3'd0, 0, 0, "rst_clear_unf");

    // underflow is sticky; stall holds; redirect overrides stall
    cyc(0,0,1,0,0,10'h005, 10'h005, 3'd0, 0, 0, "jump_005");
    cyc(0,0,0,0,1,10'h000, 10'h006, 3'd0, 0, 1, "ret_empty");
    cyc(0,0,0,0,0,10'h000, 10'h007, 3'd0, 0, 1, "unf_sticky");
    cyc(0,1,1,0,0,10'h200, 10'h200, 3'd0, 0, 1, "stall_redirect");
    cyc(0,1,0,1,0,10'h300, 10'h200, 3'd0, 0, 1, "stall_call");
    cyc(0,1,0,0,0,10'h000, 10'h200, 3'd0, 0, 1, "stall_hold");
    cyc(0,0,0,1,0,10'h300, 10'h300, 3'd1, 0, 1, "call_300");
    cyc(0,1,0,0,1,10'h000, 10'h300, 3'd1, 0, 1, "stall_ret");
    cyc(0,0,1,1,0,10'h080, 10'h080, 3'd1, 0, 1, "redir_masks_call");
    cyc(0,0,0,1,1,10'h3C0, 10'h201, 3'd0, 0, 1, "ret_beats_call");
    cyc(0,0,0,0,1,10'h000, 10'h202, 3'd0, 0, 1, "ret_empty2");
    cyc(1,0,0,0,0,10'h000, 10'h000, 3'd0, 0, 0, "final_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_W, default 10, sets the instruction address width in bits.
REQ-002 Parameter STEP, default 1, sets the sequential increment added to the PC each advancing cycle.
REQ-003 Parameter RESET_VEC, default 0, sets the PC value loaded by reset.
REQ-004 Parameter RAS_DEPTH, default 4, minimum 2, sets the return-address-stack entry count.
REQ-005 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 stall  input  1  freezes the PC and RAS when high, except as stated in REQ-015.
REQ-008 redirect_valid  input  1  branch/jump taken; the PC loads redirect_addr.
REQ-009 call_valid  input  1  call; the PC loads redirect_addr and pushes the return address.
REQ-010 ret_valid  input  1  return; the PC loads the popped RAS top.
REQ-011 redirect_addr  input  ADDR_W  target for redirect and call.
REQ-012 iaddr  output  ADDR_W  registered current instruction address.
REQ-013 ras_count  output  clog2(RAS_DEPTH+1)  number of valid RAS entries.
REQ-014 ras_ovf / ras_unf  output  1 each  sticky overflow / underflow flags.

Function
REQ-015 Next-PC priority SHALL be rst > redirect_valid > (stall: hold) > ret_valid > call_valid > sequential; redirect_valid SHALL be honoured even when stall=1.
REQ-016 When ret_valid or call_valid is masked by a higher-priority condition, it SHALL have no effect on the PC, RAS or flags that cycle.
REQ-017 Sequential: iaddr <= iaddr + STEP, modulo 2^ADDR_W, so all-ones + 1 wraps to 0.
REQ-018 Latency: a control input sampled at rising edge k SHALL be visible on iaddr immediately after edge k; there is no combinational path from inputs to iaddr.
REQ-019 Call: push (iaddr + STEP) mod 2^ADDR_W; iaddr <= redirect_addr; ras_count increments, saturating at RAS_DEPTH.
REQ-020 Call with ras_count == RAS_DEPTH: the oldest entry SHALL be overwritten (circular), ras_count SHALL stay at RAS_DEPTH, and ras_ovf SHALL set.
REQ-021 Ret with ras_count > 0: iaddr <= top entry; ras_count decrements.
REQ-022 Ret with ras_count == 0: iaddr <= iaddr + STEP; RAS unchanged; ras_unf SHALL set.
REQ-023 call_valid and ret_valid together, neither masked: ret wins per REQ-015, and the call is dropped without a push.
REQ-024 ras_ovf and ras_unf SHALL clear only on rst.
REQ-025 Stall with no redirect SHALL hold iaddr, the RAS contents, ras_count and the flags unchanged.

Reset
REQ-026 On rst=1 at a rising edge: iaddr <= RESET_VEC, ras_count <= 0, ras_ovf <= 0, ras_unf <= 0; all other inputs are ignored that cycle.
REQ-027 RAS entry contents need not be reset; they SHALL be unreachable while ras_count == 0.
REQ-028 A reset asserted mid-stall or mid-call sequence SHALL discard all pending RAS state.

Structure
REQ-029 Package pc_pkg SHALL hold the parameter defaults (ADDR_W, STEP, RESET_VEC, RAS_DEPTH) and the count-width helper constant.
REQ-030 The RAS SHALL be a sub-module ras_stack (push, pop, top, count, ovf/unf pulses), and pc_unit SHALL own next-PC selection and the sticky flags.

Verification
REQ-031 Reset then 5 free-running cycles, defaults -> iaddr 0,1,2,3,4,5; ras_count 0.
REQ-032 iaddr=0x3FF, no control, ADDR_W=10 -> next iaddr 0x000.
REQ-033 At iaddr=0x010 call to 0x100; 2 cycles sequential; ret -> iaddr 0x100,0x101,0x102,0x011; ras_count 1 then 0.
REQ-034 Five calls from 0x20, 0x30, 0x40, 0x50, 0x60 with RAS_DEPTH=4, then four rets -> ras_ovf=1; rets yield 0x61,0x51,0x41,0x31; ras_count ends at 0.
REQ-035 Ret on empty at iaddr=0x005 -> iaddr 0x006, ras_unf=1 held until rst; stall=1 with redirect_addr=0x200 -> iaddr 0x200; stall=1 with call_valid -> iaddr and ras_count unchanged.
